// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle R-type MIPS controller: state codes,
// funct field values and the ALU control encoding.
package mips_ctrl_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_WRITEBACK = 3'd4;
    localparam logic [2:0] ST_HALT      = 3'd5;

    localparam logic [5:0] OPCODE_RTYPE = 6'd0;

    localparam logic [5:0] FUNCT_ADD = 6'd32;
    localparam logic [5:0] FUNCT_SUB = 6'd34;
    localparam logic [5:0] FUNCT_AND = 6'd36;
    localparam logic [5:0] FUNCT_OR  = 6'd37;
    localparam logic [5:0] FUNCT_NOR = 6'd39;
    localparam logic [5:0] FUNCT_SLT = 6'd42;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_NOP = 4'd15;

    typedef struct packed {
        logic [3:0] alu_ctl;
        logic       illegal;
    } funct_dec_t;

endpackage

// File: rtl/mips_funct_decode.sv
// Combinational funct -> ALU control decoder; unknown funct codes are flagged
// illegal and report the NOP code.
module mips_funct_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  i_funct,
    output funct_dec_t  o_dec
);

    always_comb begin
        o_dec.alu_ctl = ALU_NOP;
        o_dec.illegal = 1'b0;
        case (i_funct)
            FUNCT_ADD: o_dec.alu_ctl = ALU_ADD;
            FUNCT_SUB: o_dec.alu_ctl = ALU_SUB;
            FUNCT_AND: o_dec.alu_ctl = ALU_AND;
            FUNCT_OR:  o_dec.alu_ctl = ALU_OR;
            FUNCT_NOR: o_dec.alu_ctl = ALU_NOR;
            FUNCT_SLT: o_dec.alu_ctl = ALU_SLT;
            default:   o_dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the R-type datapath,
// with an instruction-memory handshake, fetch timeout and sticky error flags.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RUN,
    output logic              IMEM_REQ,
    input  logic              IMEM_ACK,
    input  logic [DATA_W-1:0] INSTRUCTION,
    output logic              IR_WRITE,
    output logic              REG_READ,
    output logic [3:0]        ALU_CTL,
    output logic              REG_WRITE,
    output logic [4:0]        WRITE_REG,
    output logic              PC_WRITE,
    output logic              BUSY,
    output logic              ILLEGAL,
    output logic              TIMEOUT,
    output logic [CNT_W-1:0]  INSTR_COUNT
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [WAIT_W-1:0] r_wait;
    logic [DATA_W-1:0] r_ir;
    logic [3:0]        r_alu_ctl;
    logic [4:0]        r_write_reg;
    logic              r_illegal;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_count;

    funct_dec_t        w_dec;
    logic              w_in_fetch;
    logic              w_ir_write;
    logic              w_timeout_hit;
    logic              w_decode_illegal;
    logic              w_unused_ir;

    mips_funct_decode u_funct_decode (
        .i_funct (r_ir[5:0]),
        .o_dec   (w_dec)
    );

    assign w_in_fetch       = (r_state == ST_FETCH);
    assign w_ir_write       = w_in_fetch && IMEM_ACK;
    // ACK is still accepted on the cycle where MAX_WAIT misses have accumulated.
    assign w_timeout_hit    = w_in_fetch && !IMEM_ACK && (r_wait == WAIT_W'(MAX_WAIT));
    assign w_decode_illegal = (r_ir[31:26] != OPCODE_RTYPE) || w_dec.illegal;
    assign w_unused_ir      = ^{r_ir[25:16], r_ir[10:6]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (RUN) w_state_next = ST_FETCH;
            ST_FETCH: begin
                if (IMEM_ACK)           w_state_next = ST_DECODE;
                else if (w_timeout_hit) w_state_next = ST_HALT;
            end
            ST_DECODE:    w_state_next = w_decode_illegal ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   w_state_next = ST_WRITEBACK;
            ST_WRITEBACK: w_state_next = RUN ? ST_FETCH : ST_IDLE;
            ST_HALT:      w_state_next = ST_HALT;
            default:      w_state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_wait      <= '0;
            r_ir        <= '0;
            r_alu_ctl   <= ALU_NOP;
            r_write_reg <= '0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_in_fetch && !IMEM_ACK)
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;

            if (w_ir_write)
                r_ir <= INSTRUCTION;

            if (w_timeout_hit)
                r_timeout <= 1'b1;

            if (r_state == ST_DECODE) begin
                r_write_reg <= r_ir[15:11];
                if (w_decode_illegal)
                    r_illegal <= 1'b1;
                else
                    r_alu_ctl <= w_dec.alu_ctl;
            end

            if (r_state == ST_WRITEBACK)
                r_count <= r_count + 1'b1;
        end
    end

    // Pulses are decoded from the state register, so an asynchronous reset
    // removes them in the same instant it forces IDLE.
    assign IMEM_REQ    = w_in_fetch;
    assign IR_WRITE    = w_ir_write;
    assign REG_READ    = (r_state == ST_DECODE);
    assign PC_WRITE    = (r_state == ST_WRITEBACK);
    assign REG_WRITE   = (r_state == ST_WRITEBACK) && (r_write_reg != 5'd0);
    assign BUSY        = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign ALU_CTL     = r_alu_ctl;
    assign WRITE_REG   = r_write_reg;
    assign ILLEGAL     = r_illegal;
    assign TIMEOUT     = r_timeout;
    assign INSTR_COUNT = r_count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus a long
// randomized instruction stream checked against an instruction-level model.
module tb_mips_multicycle_ctrl;

    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 8;

    localparam int LEGAL_FUNCT [6] = '{32, 34, 36, 37, 39, 42};
    localparam int LEGAL_ALU   [6] = '{2, 6, 0, 1, 12, 7};

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              RUN = 1'b0;
    logic              IMEM_ACK = 1'b0;
    logic [DATA_W-1:0] INSTRUCTION = '0;
    logic              IMEM_REQ, IR_WRITE, REG_READ, REG_WRITE, PC_WRITE;
    logic              BUSY, ILLEGAL, TIMEOUT;
    logic [3:0]        ALU_CTL;
    logic [4:0]        WRITE_REG;
    logic [CNT_W-1:0]  INSTR_COUNT;

    int pass_cnt  = 0;
    int check_cnt = 0;
    logic [CNT_W-1:0] exp_count;

    typedef struct {
        bit         ir_write;
        bit         reg_read;
        bit         stray_ir;
        bit         fetch_lost;
        logic [3:0] alu_ex;
        logic [4:0] wreg_ex;
        logic [3:0] alu_wb;
        bit         pc_wr_wb;
        bit         reg_wr_wb;
        int         pc_writes;
        int         reg_writes;
        bit         busy_after;
        bit         req_after;
        bit         illegal;
        logic [CNT_W-1:0] count;
    } obs_t;

    mips_multicycle_ctrl #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN),
        .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK), .INSTRUCTION(INSTRUCTION),
        .IR_WRITE(IR_WRITE), .REG_READ(REG_READ), .ALU_CTL(ALU_CTL),
        .REG_WRITE(REG_WRITE), .WRITE_REG(WRITE_REG), .PC_WRITE(PC_WRITE),
        .BUSY(BUSY), .ILLEGAL(ILLEGAL), .TIMEOUT(TIMEOUT), .INSTR_COUNT(INSTR_COUNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: ALU code for a legal R-type word, -1 when the word is illegal.
    function automatic int model_alu(logic [31:0] ins);
        if (ins[31:26] != 6'd0) return -1;
        for (int k = 0; k < 6; k++)
            if (int'(ins[5:0]) == LEGAL_FUNCT[k]) return LEGAL_ALU[k];
        return -1;
    endfunction

    function automatic logic [31:0] rtype(logic [4:0] rd, int funct);
        logic [5:0] f;
        f = 6'(funct);
        return {6'd0, 5'($urandom), 5'($urandom), rd, 5'($urandom), f};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        RUN = 1'b0;
        IMEM_ACK = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_count = '0;
    endtask

    task automatic start_run();
        RUN = 1'b1;
        tick();
    endtask

    // Drives one instruction from a FETCH-state sample point through the cycle
    // after WRITEBACK, recording what the DUT showed along the way.
    task automatic do_instr(input logic [31:0] ins, input int waits, input bit run_next,
                            output obs_t o);
        o = '{default: 0};
        IMEM_ACK = 1'b0;
        for (int w = 0; w < waits; w++) begin
            INSTRUCTION = $urandom;
            #1;
            if (IMEM_REQ !== 1'b1 || IR_WRITE !== 1'b0) o.fetch_lost = 1;
            tick();
        end
        IMEM_ACK = 1'b1;
        INSTRUCTION = ins;
        #1;
        if (IMEM_REQ !== 1'b1) o.fetch_lost = 1;
        o.ir_write = IR_WRITE;
        tick();
        IMEM_ACK = 1'($urandom);
        INSTRUCTION = $urandom;
        #1;
        o.reg_read = REG_READ;
        o.stray_ir |= IR_WRITE;
        o.pc_writes += int'(PC_WRITE);
        o.reg_writes += int'(REG_WRITE);
        tick();
        RUN = run_next;
        IMEM_ACK = 1'($urandom);
        #1;
        o.alu_ex = ALU_CTL;
        o.wreg_ex = WRITE_REG;
        o.stray_ir |= IR_WRITE;
        o.pc_writes += int'(PC_WRITE);
        o.reg_writes += int'(REG_WRITE);
        tick();
        IMEM_ACK = 1'($urandom);
        #1;
        o.alu_wb = ALU_CTL;
        o.pc_wr_wb = PC_WRITE;
        o.reg_wr_wb = REG_WRITE;
        o.stray_ir |= IR_WRITE;
        o.pc_writes += int'(PC_WRITE);
        o.reg_writes += int'(REG_WRITE);
        tick();
        IMEM_ACK = 1'b0;
        #1;
        o.busy_after = BUSY;
        o.req_after = IMEM_REQ;
        o.illegal = ILLEGAL;
        o.count = INSTR_COUNT;
    endtask

    task automatic test_reset();
        apply_reset();
        check_cnt++;
        if ({BUSY, IMEM_REQ, IR_WRITE, REG_READ, REG_WRITE, PC_WRITE, ILLEGAL, TIMEOUT} !== 8'h00)
            $display("FAIL reset_flags: got %b want 00000000",
                     {BUSY, IMEM_REQ, IR_WRITE, REG_READ, REG_WRITE, PC_WRITE, ILLEGAL, TIMEOUT});
        else pass_cnt++;
        check_cnt++;
        if (ALU_CTL !== 4'hF || WRITE_REG !== 5'd0 || INSTR_COUNT !== '0)
            $display("FAIL reset_regs: got alu=%h wr=%0d cnt=%0d want alu=f wr=0 cnt=0",
                     ALU_CTL, WRITE_REG, INSTR_COUNT);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (BUSY !== 1'b0)
            $display("FAIL idle_hold: got busy=%b want 0 with RUN=0", BUSY);
        else pass_cnt++;
        start_run();
        check_cnt++;
        if (IMEM_REQ !== 1'b1 || BUSY !== 1'b1)
            $display("FAIL idle_to_fetch: got req=%b busy=%b want 1 1", IMEM_REQ, BUSY);
        else pass_cnt++;
    endtask

    task automatic test_add();
        obs_t o;
        do_instr(32'h0022_1020, 0, 1'b1, o);
        exp_count = exp_count + 1'b1;
        check_cnt++;
        if (!o.ir_write || !o.reg_read)
            $display("FAIL add_handshake: got ir_write=%b reg_read=%b want 1 1", o.ir_write, o.reg_read);
        else pass_cnt++;
        check_cnt++;
        if (o.alu_ex !== 4'd2 || o.wreg_ex !== 5'd2)
            $display("FAIL add_decode: got alu=%0d wr=%0d want alu=2 wr=2", o.alu_ex, o.wreg_ex);
        else pass_cnt++;
        check_cnt++;
        if (!o.pc_wr_wb || !o.reg_wr_wb)
            $display("FAIL add_cycle4_writes: got pc=%b reg=%b want 1 1", o.pc_wr_wb, o.reg_wr_wb);
        else pass_cnt++;
        check_cnt++;
        if (o.count !== exp_count || !o.req_after)
            $display("FAIL add_retire: got cnt=%0d req=%b want cnt=%0d req=1", o.count, o.req_after, exp_count);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        obs_t o;
        int seq [5] = '{36, 37, 34, 42, 39};
        logic [31:0] ins;
        apply_reset();
        start_run();
        foreach (seq[k]) begin
            ins = rtype(5'($urandom_range(1, 31)), seq[k]);
            do_instr(ins, 0, 1'b1, o);
            exp_count = exp_count + 1'b1;
            check_cnt++;
            if (o.alu_wb !== 4'(model_alu(ins)) || o.wreg_ex !== ins[15:11])
                $display("FAIL stream_alu funct=%0d: got alu=%0d wr=%0d want alu=%0d wr=%0d",
                         seq[k], o.alu_wb, o.wreg_ex, model_alu(ins), ins[15:11]);
            else pass_cnt++;
        end
        check_cnt++;
        if (o.count !== exp_count || exp_count !== CNT_W'(5))
            $display("FAIL stream_count: got %0d want 5", o.count);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        obs_t o;
        logic [31:0] cases [4];
        cases[0] = 32'h0022_103F;
        cases[1] = 32'h0822_1020;
        cases[2] = {6'($urandom_range(1, 63)), 26'($urandom)};
        cases[3] = rtype(5'd7, 33);
        foreach (cases[k]) begin
            apply_reset();
            start_run();
            do_instr(cases[k], 0, 1'b1, o);
            check_cnt++;
            if (!o.illegal || o.pc_writes != 0 || o.reg_writes != 0)
                $display("FAIL illegal_%0d ins=%h: got ill=%b pc=%0d reg=%0d want 1 0 0",
                         k, cases[k], o.illegal, o.pc_writes, o.reg_writes);
            else pass_cnt++;
            check_cnt++;
            if (o.busy_after || o.req_after || o.count !== '0)
                $display("FAIL illegal_halt_%0d: got busy=%b req=%b cnt=%0d want 0 0 0",
                         k, o.busy_after, o.req_after, o.count);
            else pass_cnt++;
        end
        RUN = 1'b1;
        IMEM_ACK = 1'b1;
        repeat (3) tick();
        check_cnt++;
        if (BUSY !== 1'b0 || IMEM_REQ !== 1'b0 || IR_WRITE !== 1'b0 || ILLEGAL !== 1'b1)
            $display("FAIL halt_absorbing: got busy=%b req=%b irw=%b ill=%b want 0 0 0 1",
                     BUSY, IMEM_REQ, IR_WRITE, ILLEGAL);
        else pass_cnt++;
        apply_reset();
        check_cnt++;
        if (ILLEGAL !== 1'b0)
            $display("FAIL illegal_cleared: got %b want 0", ILLEGAL);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        obs_t o;
        apply_reset();
        start_run();
        IMEM_ACK = 1'b0;
        repeat (MAX_WAIT) tick();
        check_cnt++;
        if (IMEM_REQ !== 1'b1 || TIMEOUT !== 1'b0)
            $display("FAIL timeout_early: got req=%b to=%b after %0d waits want 1 0", IMEM_REQ, TIMEOUT, MAX_WAIT);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (TIMEOUT !== 1'b1 || BUSY !== 1'b0 || IMEM_REQ !== 1'b0)
            $display("FAIL timeout_halt: got to=%b busy=%b req=%b want 1 0 0", TIMEOUT, BUSY, IMEM_REQ);
        else pass_cnt++;
        IMEM_ACK = 1'b1;
        #1;
        check_cnt++;
        if (IR_WRITE !== 1'b0)
            $display("FAIL timeout_late_ack: got ir_write=%b want 0", IR_WRITE);
        else pass_cnt++;
        apply_reset();
        check_cnt++;
        if (TIMEOUT !== 1'b0)
            $display("FAIL timeout_cleared: got %b want 0", TIMEOUT);
        else pass_cnt++;
        start_run();
        do_instr(32'h0022_1020, MAX_WAIT, 1'b1, o);
        exp_count = exp_count + 1'b1;
        check_cnt++;
        if (o.fetch_lost || !o.ir_write || !o.pc_wr_wb || o.count !== exp_count || TIMEOUT !== 1'b0)
            $display("FAIL ack_last_wait: got lost=%b irw=%b pc=%b cnt=%0d to=%b want 0 1 1 %0d 0",
                     o.fetch_lost, o.ir_write, o.pc_wr_wb, o.count, TIMEOUT, exp_count);
        else pass_cnt++;
    endtask

    task automatic test_rd_zero();
        obs_t o;
        do_instr(32'h0022_0020, 0, 1'b1, o);
        exp_count = exp_count + 1'b1;
        check_cnt++;
        if (!o.pc_wr_wb || o.reg_writes != 0 || o.count !== exp_count)
            $display("FAIL rd_zero: got pc=%b reg=%0d cnt=%0d want 1 0 %0d",
                     o.pc_wr_wb, o.reg_writes, o.count, exp_count);
        else pass_cnt++;
    endtask

    task automatic test_run_drop();
        obs_t o;
        do_instr(rtype(5'd9, 34), 0, 1'b0, o);
        exp_count = exp_count + 1'b1;
        check_cnt++;
        if (!o.pc_wr_wb || !o.reg_wr_wb || o.busy_after || o.req_after || o.count !== exp_count)
            $display("FAIL run_drop: got pc=%b reg=%b busy=%b req=%b cnt=%0d want 1 1 0 0 %0d",
                     o.pc_wr_wb, o.reg_wr_wb, o.busy_after, o.req_after, o.count, exp_count);
        else pass_cnt++;
        repeat (3) tick();
        check_cnt++;
        if (BUSY !== 1'b0)
            $display("FAIL run_drop_idle: got busy=%b want 0", BUSY);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int writes;
        start_run();
        IMEM_ACK = 1'b1;
        INSTRUCTION = 32'h0022_1020;
        tick();
        IMEM_ACK = 1'b0;
        check_cnt++;
        if (REG_READ !== 1'b1)
            $display("FAIL reset_mid_decode: got reg_read=%b want 1", REG_READ);
        else pass_cnt++;
        #2;
        RESET = 1'b1;
        #1;
        check_cnt++;
        if (BUSY !== 1'b0 || REG_READ !== 1'b0 || INSTR_COUNT !== '0 || ALU_CTL !== 4'hF)
            $display("FAIL reset_mid_async: got busy=%b rr=%b cnt=%0d alu=%h want 0 0 0 f",
                     BUSY, REG_READ, INSTR_COUNT, ALU_CTL);
        else pass_cnt++;
        writes = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            writes += int'(PC_WRITE) + int'(REG_WRITE);
        end
        RESET = 1'b0;
        RUN = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            writes += int'(PC_WRITE) + int'(REG_WRITE);
        end
        check_cnt++;
        if (writes != 0 || BUSY !== 1'b0)
            $display("FAIL reset_mid_suppress: got writes=%0d busy=%b want 0 0", writes, BUSY);
        else pass_cnt++;
        exp_count = '0;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic [31:0] ins;
        logic [4:0] rd;
        int waits;
        bit run_next;
        int fails_here;
        int wraps;
        apply_reset();
        start_run();
        fails_here = 0;
        wraps = 0;
        for (int n = 0; n < 300; n++) begin
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ins = rtype(rd, LEGAL_FUNCT[$urandom_range(0, 5)]);
            waits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAX_WAIT) : 0;
            run_next = ($urandom_range(0, 7) != 0);
            do_instr(ins, waits, run_next, o);
            exp_count = exp_count + 1'b1;
            if (exp_count == '0) wraps++;
            check_cnt++;
            if (o.fetch_lost || !o.ir_write || o.stray_ir || !o.reg_read)
                $display("FAIL b2b_fetch n=%0d: got lost=%b irw=%b stray=%b rr=%b want 0 1 0 1",
                         n, o.fetch_lost, o.ir_write, o.stray_ir, o.reg_read);
            else pass_cnt++;
            check_cnt++;
            if (o.alu_ex !== 4'(model_alu(ins)) || o.alu_wb !== 4'(model_alu(ins)) || o.wreg_ex !== rd)
                $display("FAIL b2b_decode n=%0d ins=%h: got alu=%0d/%0d wr=%0d want alu=%0d wr=%0d",
                         n, ins, o.alu_ex, o.alu_wb, o.wreg_ex, model_alu(ins), rd);
            else pass_cnt++;
            check_cnt++;
            if (o.pc_writes != 1 || o.reg_writes != ((rd != 0) ? 1 : 0))
                $display("FAIL b2b_writes n=%0d rd=%0d: got pc=%0d reg=%0d want 1 %0d",
                         n, rd, o.pc_writes, o.reg_writes, (rd != 0) ? 1 : 0);
            else pass_cnt++;
            check_cnt++;
            if (o.count !== exp_count || o.busy_after !== run_next)
                $display("FAIL b2b_retire n=%0d: got cnt=%0d busy=%b want cnt=%0d busy=%b",
                         n, o.count, o.busy_after, exp_count, run_next);
            else pass_cnt++;
            if (!run_next) begin
                repeat ($urandom_range(0, 2)) tick();
                start_run();
            end
        end
        check_cnt++;
        if (wraps < 1 || INSTR_COUNT !== CNT_W'(300 % (1 << CNT_W)))
            $display("FAIL count_wrap: got cnt=%0d wraps=%0d want cnt=%0d wraps>=1",
                     INSTR_COUNT, wraps, 300 % (1 << CNT_W));
        else pass_cnt++;
    endtask

    initial begin
        exp_count = '0;
        test_reset();
        test_add();
        test_stream();
        test_rd_zero();
        test_run_drop();
        test_reset_mid();
        test_illegal();
        test_timeout();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
